// File: rtl/id_ex_if.sv
// ID/EX pipeline register bus: D-stage capture inputs, W-stage refresh bus and
// the registered E-stage outputs presented to the ALU and hazard unit.
interface id_ex_if;
  logic        flush_E;
  logic        hold_E;
  logic [31:0] IR_D;
  logic [31:0] PC8_D;
  logic [31:0] RD1_D;
  logic [31:0] RD2_D;
  logic        W_we;
  logic [4:0]  W_addr;
  logic [31:0] W_data;
  logic [31:0] IR_E;
  logic [31:0] PC8_E;
  logic [31:0] A_E;
  logic [31:0] B_E;
  logic [31:0] RT_E;
  logic [2:0]  ALUop_E;
  logic [4:0]  WA_E;
  logic [1:0]  Tnew_E;
  logic        valid_E;

  modport master (
    output flush_E, hold_E, IR_D, PC8_D, RD1_D, RD2_D, W_we, W_addr, W_data,
    input  IR_E, PC8_E, A_E, B_E, RT_E, ALUop_E, WA_E, Tnew_E, valid_E
  );

  modport slave (
    input  flush_E, hold_E, IR_D, PC8_D, RD1_D, RD2_D, W_we, W_addr, W_data,
    output IR_E, PC8_E, A_E, B_E, RT_E, ALUop_E, WA_E, Tnew_E, valid_E
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush/hold and registered decode of the ALU controls.
// Optional macro ID_EX_W_REFRESH_EN refreshes held operands from the W-stage write bus.
module id_ex_reg (
  input  logic   clk,
  input  logic   reset,
  id_ex_if.slave bus
);

  localparam logic [1:0] BSRC_RT   = 2'd0;
  localparam logic [1:0] BSRC_ZEXT = 2'd1;
  localparam logic [1:0] BSRC_SEXT = 2'd2;

  typedef struct packed {
    logic [2:0] alu_op;
    logic [1:0] bsrc;
    logic [4:0] wa;
    logic [1:0] tnew;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d.alu_op = 3'd0;
    d.bsrc   = BSRC_RT;
    d.wa     = 5'd0;
    d.tnew   = 2'd0;
    case (ir[31:26])
      6'b000000: begin
        case (ir[5:0])
          6'b100001: begin d.alu_op = 3'd0; d.wa = ir[15:11]; d.tnew = 2'd1; end
          6'b100011: begin d.alu_op = 3'd1; d.wa = ir[15:11]; d.tnew = 2'd1; end
          default:   d.wa = 5'd0;
        endcase
      end
      6'b001101: begin d.alu_op = 3'd2; d.bsrc = BSRC_ZEXT; d.wa = ir[20:16]; d.tnew = 2'd1; end
      6'b001111: begin d.alu_op = 3'd3; d.bsrc = BSRC_ZEXT; d.wa = ir[20:16]; d.tnew = 2'd1; end
      6'b001001: begin d.bsrc = BSRC_SEXT; d.wa = ir[20:16]; d.tnew = 2'd1; end
      6'b100011: begin d.bsrc = BSRC_SEXT; d.wa = ir[20:16]; d.tnew = 2'd2; end
      6'b101011: d.bsrc = BSRC_SEXT;
      6'b000011: d.wa = 5'd31;
      default:   d.wa = 5'd0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] b_select(input logic [1:0] bsrc, input logic [15:0] imm,
                                           input logic [31:0] rt_val);
    logic [31:0] b;
    case (bsrc)
      BSRC_ZEXT: b = {16'h0000, imm};
      BSRC_SEXT: b = {{16{imm[15]}}, imm};
      default:   b = rt_val;
    endcase
    return b;
  endfunction

  logic [31:0] ir_q, ir_d, pc8_q, pc8_d, a_q, a_d, b_q, b_d, rt_q, rt_d;
  logic [2:0]  aluop_q, aluop_d;
  logic [4:0]  wa_q, wa_d;
  logic [1:0]  tnew_q, tnew_d;
  logic        valid_q, valid_d;
  dec_t        dec_in_s;

  assign dec_in_s = decode(bus.IR_D);

`ifdef ID_EX_W_REFRESH_EN
  dec_t dec_held_s;
  assign dec_held_s = decode(ir_q);
`else
  logic unused_w_bus_s;
  assign unused_w_bus_s = ^{bus.W_we, bus.W_addr, bus.W_data};
`endif

  // Next-state selection: flush > hold (with optional W refresh) > normal load.
  always_comb begin
    ir_d    = ir_q;
    pc8_d   = pc8_q;
    a_d     = a_q;
    b_d     = b_q;
    rt_d    = rt_q;
    aluop_d = aluop_q;
    wa_d    = wa_q;
    tnew_d  = tnew_q;
    valid_d = valid_q;
    if (bus.flush_E) begin
      ir_d    = 32'h0000_0000;
      pc8_d   = 32'h0000_0000;
      a_d     = 32'h0000_0000;
      b_d     = 32'h0000_0000;
      rt_d    = 32'h0000_0000;
      aluop_d = 3'd0;
      wa_d    = 5'd0;
      tnew_d  = 2'd0;
      valid_d = 1'b0;
    end else if (bus.hold_E) begin
`ifdef ID_EX_W_REFRESH_EN
      if (bus.W_we && (bus.W_addr != 5'd0)) begin
        if (bus.W_addr == ir_q[25:21]) begin
          a_d = bus.W_data;
        end else begin
          a_d = a_q;
        end
        if (bus.W_addr == ir_q[20:16]) begin
          rt_d = bus.W_data;
          b_d  = (dec_held_s.bsrc == BSRC_RT) ? bus.W_data : b_q;
        end else begin
          rt_d = rt_q;
          b_d  = b_q;
        end
      end else begin
        a_d = a_q;
      end
`else
      a_d = a_q;
`endif
    end else begin
      ir_d    = bus.IR_D;
      pc8_d   = bus.PC8_D;
      a_d     = bus.RD1_D;
      rt_d    = bus.RD2_D;
      b_d     = b_select(dec_in_s.bsrc, bus.IR_D[15:0], bus.RD2_D);
      aluop_d = dec_in_s.alu_op;
      wa_d    = dec_in_s.wa;
      tnew_d  = dec_in_s.tnew;
      valid_d = 1'b1;
    end
  end

  // Pipeline state register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q    <= 32'h0000_0000;
      pc8_q   <= 32'h0000_0000;
      a_q     <= 32'h0000_0000;
      b_q     <= 32'h0000_0000;
      rt_q    <= 32'h0000_0000;
      aluop_q <= 3'd0;
      wa_q    <= 5'd0;
      tnew_q  <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      pc8_q   <= pc8_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rt_q    <= rt_d;
      aluop_q <= aluop_d;
      wa_q    <= wa_d;
      tnew_q  <= tnew_d;
      valid_q <= valid_d;
    end
  end

  assign bus.IR_E    = ir_q;
  assign bus.PC8_E   = pc8_q;
  assign bus.A_E     = a_q;
  assign bus.B_E     = b_q;
  assign bus.RT_E    = rt_q;
  assign bus.ALUop_E = aluop_q;
  assign bus.WA_E    = wa_q;
  assign bus.Tnew_E  = tnew_q;
  assign bus.valid_E = valid_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: directed vectors push expected E-stage state,
// a monitor compares one entry after every rising edge.
module tb_id_ex_reg;

  typedef struct {
    logic [31:0] ir, pc8, a, b, rt;
    logic [2:0]  aluop;
    logic [4:0]  wa;
    logic [1:0]  tnew;
    logic        valid;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  id_ex_if bus ();

  id_ex_reg dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk32({tag, ".IR_E"},    bus.IR_E, e.ir);
    chk32({tag, ".PC8_E"},   bus.PC8_E, e.pc8);
    chk32({tag, ".A_E"},     bus.A_E, e.a);
    chk32({tag, ".B_E"},     bus.B_E, e.b);
    chk32({tag, ".RT_E"},    bus.RT_E, e.rt);
    chk32({tag, ".ALUop_E"}, {29'd0, bus.ALUop_E}, {29'd0, e.aluop});
    chk32({tag, ".WA_E"},    {27'd0, bus.WA_E}, {27'd0, e.wa});
    chk32({tag, ".Tnew_E"},  {30'd0, bus.Tnew_E}, {30'd0, e.tnew});
    chk32({tag, ".valid_E"}, {31'd0, bus.valid_E}, {31'd0, e.valid});
  endtask

  function automatic exp_t mk(input logic [31:0] ir, pc8, a, b, rt, input logic [2:0] aluop,
                              input logic [4:0] wa, input logic [1:0] tnew, input logic valid);
    exp_t e;
    e.ir = ir; e.pc8 = pc8; e.a = a; e.b = b; e.rt = rt;
    e.aluop = aluop; e.wa = wa; e.tnew = tnew; e.valid = valid;
    return e;
  endfunction

  exp_t zero_e;
  exp_t last_e;
  int   pops = 0;

  // Monitor: after each rising edge compare against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      pops++;
      chk_all($sformatf("edge%0d", pops), e);
    end
  end

  task automatic drive(input logic fl, input logic hd, input logic [31:0] ir, pc8, rd1, rd2,
                       input logic we, input logic [4:0] wad, input logic [31:0] wd);
    @(negedge clk);
    bus.flush_E = fl; bus.hold_E = hd;
    bus.IR_D = ir; bus.PC8_D = pc8; bus.RD1_D = rd1; bus.RD2_D = rd2;
    bus.W_we = we; bus.W_addr = wad; bus.W_data = wd;
  endtask

  task automatic step(input logic fl, input logic hd, input logic [31:0] ir, pc8, rd1, rd2,
                      input logic we, input logic [4:0] wad, input logic [31:0] wd, input exp_t e);
    drive(fl, hd, ir, pc8, rd1, rd2, we, wad, wd);
    exp_q.push_back(e);
    last_e = e;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #2; n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    exp_t e;
    zero_e = mk(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0, 5'd0, 2'd0, 1'b0);
    bus.flush_E = 1'b0; bus.hold_E = 1'b0;
    bus.IR_D = 32'h0022_1821; bus.PC8_D = 32'hDEAD_BEEF;
    bus.RD1_D = 32'h1234_5678; bus.RD2_D = 32'h8765_4321;
    bus.W_we = 1'b1; bus.W_addr = 5'd1; bus.W_data = 32'hFFFF_FFFF;

    // Reset held with arbitrary inputs across edges
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", zero_e);

    @(negedge clk); reset = 1'b1;
    step(1'b0, 1'b0, 32'h0022_1821, 32'h0000_0100, 32'd5, 32'd7, 1'b1, 5'd1, 32'h55,
         mk(32'h0022_1821, 32'h100, 32'd5, 32'd7, 32'd7, 3'd0, 5'd3, 2'd1, 1'b1));
    step(1'b0, 1'b0, 32'h3404_8000, 32'h0000_0104, 32'h11, 32'h22, 1'b0, 5'd0, 32'h0,
         mk(32'h3404_8000, 32'h104, 32'h11, 32'h0000_8000, 32'h22, 3'd2, 5'd4, 2'd1, 1'b1));
    step(1'b0, 1'b0, 32'h2404_8000, 32'h0000_0108, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0,
         mk(32'h2404_8000, 32'h108, 32'h1, 32'hFFFF_8000, 32'h2, 3'd0, 5'd4, 2'd1, 1'b1));
    step(1'b0, 1'b0, 32'h8CC5_FFFC, 32'h0000_010C, 32'h1000, 32'h9, 1'b0, 5'd0, 32'h0,
         mk(32'h8CC5_FFFC, 32'h10C, 32'h1000, 32'hFFFF_FFFC, 32'h9, 3'd0, 5'd5, 2'd2, 1'b1));
    step(1'b0, 1'b0, 32'hACC5_0008, 32'h0000_0110, 32'h2000, 32'h1234, 1'b0, 5'd0, 32'h0,
         mk(32'hACC5_0008, 32'h110, 32'h2000, 32'h8, 32'h1234, 3'd0, 5'd0, 2'd0, 1'b1));
    step(1'b0, 1'b0, 32'h3C07_ABCD, 32'h0000_0114, 32'h3, 32'h4, 1'b0, 5'd0, 32'h0,
         mk(32'h3C07_ABCD, 32'h114, 32'h3, 32'h0000_ABCD, 32'h4, 3'd3, 5'd7, 2'd1, 1'b1));
    step(1'b0, 1'b0, 32'h0C00_0010, 32'h0000_0118, 32'h6, 32'h66, 1'b0, 5'd0, 32'h0,
         mk(32'h0C00_0010, 32'h118, 32'h6, 32'h66, 32'h66, 3'd0, 5'd31, 2'd0, 1'b1));
    step(1'b0, 1'b0, 32'h1022_0003, 32'h0000_011C, 32'h8, 32'h88, 1'b0, 5'd0, 32'h0,
         mk(32'h1022_0003, 32'h11C, 32'h8, 32'h88, 32'h88, 3'd0, 5'd0, 2'd0, 1'b1));
    step(1'b0, 1'b0, 32'hFC00_0000, 32'h0000_0120, 32'h9, 32'h99, 1'b0, 5'd0, 32'h0,
         mk(32'hFC00_0000, 32'h120, 32'h9, 32'h99, 32'h99, 3'd0, 5'd0, 2'd0, 1'b1));
    step(1'b0, 1'b0, 32'h0022_0021, 32'h0000_0124, 32'hA, 32'hB, 1'b0, 5'd0, 32'h0,
         mk(32'h0022_0021, 32'h124, 32'hA, 32'hB, 32'hB, 3'd0, 5'd0, 2'd1, 1'b1));
    step(1'b0, 1'b0, 32'h012A_4023, 32'h0000_0128, 32'd100, 32'd30, 1'b0, 5'd0, 32'h0,
         mk(32'h012A_4023, 32'h128, 32'd100, 32'd30, 32'd30, 3'd1, 5'd8, 2'd1, 1'b1));
    // Hold three cycles with new D inputs: outputs frozen
    e = last_e;
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'h3404_FFFF, 32'h200 + i, 32'h77, 32'h78, 1'b0, 5'd0, 32'h0, e);
    // Flush and hold together: flush wins
    step(1'b1, 1'b1, 32'h3404_FFFF, 32'h300, 32'h77, 32'h78, 1'b0, 5'd0, 32'h0, zero_e);

    // W-stage refresh while holding addu $3,$1,$2
    step(1'b0, 1'b0, 32'h0022_1821, 32'h0000_0400, 32'd5, 32'd7, 1'b0, 5'd0, 32'h0,
         mk(32'h0022_1821, 32'h400, 32'd5, 32'd7, 32'd7, 3'd0, 5'd3, 2'd1, 1'b1));
    e = last_e;
`ifdef ID_EX_W_REFRESH_EN
    e.a = 32'hAA;
`endif
    step(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd1, 32'hAA, e);
    step(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd0, 32'hBB, e);
`ifdef ID_EX_W_REFRESH_EN
    e.rt = 32'hCC; e.b = 32'hCC;
`endif
    step(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd2, 32'hCC, e);
    step(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd1, 32'hDD, e);
    drain();

    // Async reset pulse between edges during a hold
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk_all("async_reset", zero_e);
    @(negedge clk); reset = 1'b1;
    step(1'b0, 1'b0, 32'h3405_0001, 32'h0000_0500, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0,
         mk(32'h3405_0001, 32'h500, 32'h1, 32'h1, 32'h2, 3'd2, 5'd5, 2'd1, 1'b1));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
